kbd_text_arbiter: RTL



---
 rtl/kbd_text_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/kbd_text_arbiter.sv
// Schedules PS/2 keys and a downloaded text file into the PIA keyboard slot; PS/2 direct path 1 cycle,
// text 4 cycles after download ends; PS/2 wins the slot, one held key absorbs CPU backpressure, more are dropped.
module kbd_text_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int CR_GAP   = 250000,
  parameter int CHAR_GAP = 2500
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ps2_valid,
  input  logic [6:0]        ps2_ascii,
  input  logic              kbd_ack,
  output logic [6:0]        kbd_data,
  output logic              kbd_ready,
  output logic              busy,
  output logic              ps2_overrun
);
  localparam int GAP_MAX = (CR_GAP > CHAR_GAP) ? CR_GAP : CHAR_GAP;
  localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_READ, S_PRESENT, S_WAIT_ACK, S_DELAY
  } state_t;

  state_t            r_state, w_next;
  logic              r_dl_d;
  logic [7:0]        r_mem [0:(2**ADDR_W)-1];
  logic [7:0]        r_rd_dat;
  logic [ADDR_W:0]   r_len, r_ptr;
  logic              r_prev_cr;
  logic [6:0]        r_txt;
  logic [GAP_W-1:0]  r_cnt;
  logic              r_hold_vld;
  logic [6:0]        r_hold_dat;
  logic              r_kbd_ready;
  logic [6:0]        r_kbd_data;
  logic              r_ovr;

  logic              w_dl_rise, w_dl_fall, w_wr, w_ack, w_esc, w_txt_load, w_drop, w_gap_done;
  logic [6:0]        w_byte, w_filt;
  logic [ADDR_W:0]   w_ptr_inc;
  logic [ADDR_W-1:0] w_ram_addr;

  assign w_dl_rise  = ioctl_download & ~r_dl_d;
  assign w_dl_fall  = ~ioctl_download & r_dl_d;
  assign w_wr       = ioctl_download & ioctl_wr;
  assign w_ack      = kbd_ack & r_kbd_ready;
  assign w_ptr_inc  = r_ptr + 1'b1;
  assign w_gap_done = (r_cnt <= GAP_W'(1));
  assign w_ram_addr = ioctl_download ? ioctl_addr : r_ptr[ADDR_W-1:0];

  // Filter: a LF right after a CR is swallowed, any other LF becomes CR
  assign w_byte = 7'(r_rd_dat & 8'h7F);
  assign w_drop = (w_byte == 7'h0A) && r_prev_cr;
  assign w_filt = (w_byte >= 7'h61 && w_byte <= 7'h7A) ? (w_byte - 7'h20) :
                  (w_byte == 7'h0A) ? 7'h0D : w_byte;

  assign w_esc = ps2_valid && (ps2_ascii == 7'h1B) &&
                 (r_state inside {S_FETCH, S_READ, S_PRESENT, S_WAIT_ACK, S_DELAY});
  // A same-cycle keystroke takes the slot ahead of the pending text character
  assign w_txt_load = (r_state == S_PRESENT) && !r_kbd_ready && !r_hold_vld && !ps2_valid;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dl_d  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dl_d  <= ioctl_download;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_dl_rise) begin
      w_next = S_LOAD;
    end else if (w_esc) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_LOAD:     if (w_dl_fall) w_next = (r_len != '0) ? S_FETCH : S_IDLE;
        S_FETCH:    w_next = S_READ;
        S_READ:     if (w_drop) w_next = (w_ptr_inc == r_len) ? S_IDLE : S_FETCH;
                    else        w_next = S_PRESENT;
        S_PRESENT:  if (w_txt_load) w_next = S_WAIT_ACK;
        S_WAIT_ACK: if (w_ack) w_next = S_DELAY;
        S_DELAY:    if (w_gap_done) w_next = (r_ptr < r_len) ? S_FETCH : S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk25) begin
    if (w_wr) r_mem[ioctl_addr] <= ioctl_dout;
    r_rd_dat <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_ptr     <= '0;
      r_prev_cr <= 1'b0;
      r_txt     <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_wr)           r_len <= {1'b0, ioctl_addr} + 1'b1;
      else if (w_dl_rise) r_len <= '0;
      if (r_state == S_LOAD) begin
        r_ptr     <= '0;
        r_prev_cr <= 1'b0;
      end else if (r_state == S_READ) begin
        r_ptr     <= w_ptr_inc;
        r_prev_cr <= (w_byte == 7'h0D);
        if (!w_drop) r_txt <= w_filt;
      end
      if (r_state == S_WAIT_ACK && w_ack)
        r_cnt <= (r_txt == 7'h0D) ? GAP_W'(CR_GAP) : GAP_W'(CHAR_GAP);
      else if (r_state == S_DELAY && !w_gap_done)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Slot frees on the ack edge, so any reload is visible one cycle later
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_kbd_ready <= 1'b0;
      r_kbd_data  <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_dat  <= '0;
      r_ovr       <= 1'b0;
    end else begin
      if (w_ack) r_kbd_ready <= 1'b0;
      if (!r_kbd_ready) begin
        if (r_hold_vld) begin
          r_kbd_data  <= r_hold_dat;
          r_kbd_ready <= 1'b1;
          r_hold_vld  <= 1'b0;
        end else if (ps2_valid) begin
          r_kbd_data  <= ps2_ascii;
          r_kbd_ready <= 1'b1;
        end else if (w_txt_load) begin
          r_kbd_data  <= r_txt;
          r_kbd_ready <= 1'b1;
        end
      end
      if (ps2_valid) begin
        if (r_hold_vld) begin
          r_ovr <= 1'b1;
        end else if (r_kbd_ready) begin
          r_hold_vld <= 1'b1;
          r_hold_dat <= ps2_ascii;
        end
      end
    end
  end

  assign kbd_data    = r_kbd_data;
  assign kbd_ready   = r_kbd_ready;
  assign ps2_overrun = r_ovr;
endmodule
